// File: rtl/write_back_pipe_if.sv
// MEM-stage to write-back bus: captured instruction fields in, one registered
// register-file write out.
interface write_back_pipe_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic                  reg_write_in;
  logic [1:0]            wb_sel;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       mem_data;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       imm;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  wb_valid;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       write_data;
  logic                  misalign;

  modport master (
    output in_valid, stall, flush, reg_write_in, wb_sel, funct3,
           alu_result, mem_data, pc_plus4, imm, rd_in,
    input  wb_valid, reg_write, rd, write_data, misalign
  );

  modport slave (
    input  in_valid, stall, flush, reg_write_in, wb_sel, funct3,
           alu_result, mem_data, pc_plus4, imm, rd_in,
    output wb_valid, reg_write, rd, write_data, misalign
  );
endinterface

// File: rtl/write_back_pipe.sv
// Registered write-back stage: result select, load align/extend, x0 suppression,
// misalign flag. Define WB_RETIRE_CNT_EN to add the 64-bit retire_count output.
module write_back_pipe #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]        retire_count,
`endif
  write_back_pipe_if.slave   bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic [OFF_W-1:0]      w_off;
  logic [XLEN-1:0]       w_shifted;
  logic [63:0]           w_sh64;
  logic [63:0]           w_ext64;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_is_load;
  logic                  w_load_mis;
  logic                  w_live;
  logic                  w_capture;

  logic                  r_wb_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_write_data;
  logic                  r_misalign;

  assign w_off     = bus.alu_result[OFF_W-1:0];
  assign w_shifted = bus.mem_data >> {w_off, 3'b000};
  // Extending in a 64-bit domain then truncating makes LD/LWU collapse to LW when XLEN=32.
  assign w_sh64    = 64'(w_shifted);
  assign w_is_load = (bus.wb_sel == 2'b01);
  assign w_live    = bus.in_valid & ~bus.flush;
  assign w_capture = bus.flush | ~bus.stall;

  always_comb begin
    w_ext64 = '0;
    case (bus.funct3)
      3'b000:  w_ext64 = {{56{w_sh64[7]}},  w_sh64[7:0]};
      3'b001:  w_ext64 = {{48{w_sh64[15]}}, w_sh64[15:0]};
      3'b010:  w_ext64 = {{32{w_sh64[31]}}, w_sh64[31:0]};
      3'b011:  w_ext64 = w_sh64;
      3'b100:  w_ext64 = {56'b0, w_sh64[7:0]};
      3'b101:  w_ext64 = {48'b0, w_sh64[15:0]};
      3'b110:  w_ext64 = {32'b0, w_sh64[31:0]};
      default: w_ext64 = '0;
    endcase
  end

  always_comb begin
    w_load_mis = 1'b0;
    case (bus.funct3)
      3'b001, 3'b101: w_load_mis = w_off[0];
      3'b010, 3'b110: w_load_mis = (w_off[1:0] != 2'b00);
      3'b011:         w_load_mis = (w_off != '0);
      default:        w_load_mis = 1'b0;
    endcase
  end

  always_comb begin
    w_sel_data = bus.alu_result;
    case (bus.wb_sel)
      2'b00: w_sel_data = bus.alu_result;
      2'b01: w_sel_data = w_ext64[XLEN-1:0];
      2'b10: w_sel_data = bus.pc_plus4;
      2'b11: w_sel_data = bus.imm;
      default: w_sel_data = bus.alu_result;
    endcase
  end

  // Flush forces a capture so the live bits clear even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
      r_misalign   <= 1'b0;
    end else if (w_capture) begin
      r_wb_valid   <= w_live;
      r_reg_write  <= w_live & bus.reg_write_in & (bus.rd_in != '0);
      r_rd         <= bus.rd_in;
      r_write_data <= w_sel_data;
      r_misalign   <= w_live & w_is_load & w_load_mis;
    end
  end

  assign bus.wb_valid   = r_wb_valid;
  assign bus.reg_write  = r_reg_write;
  assign bus.rd         = r_rd;
  assign bus.write_data = r_write_data;
  assign bus.misalign   = r_misalign;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_retire_count <= '0;
    else if (bus.in_valid & ~bus.stall & ~bus.flush)
      r_retire_count <= r_retire_count + 64'd1;
  end

  assign retire_count = r_retire_count;
`endif
endmodule
